// File: rtl/spi_apb_arbiter_if.sv
// Bundle of the two requester ports, the bridge-side request/response signals
// and the busy flag shared by spi_apb_arbiter and whatever drives it.
interface spi_apb_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_done;
  logic [31:0] m0_rdata;
  logic        m0_err;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_done;
  logic [31:0] m1_rdata;
  logic        m1_err;

  logic        down_write;
  logic        down_read;
  logic [31:0] down_addr;
  logic [31:0] down_wdata;
  logic [31:0] down_rdata;
  logic        down_ready;
  logic        down_error;

  logic        busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_done, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_done, m1_rdata, m1_err,
    output down_write, down_read, down_addr, down_wdata,
    input  down_rdata, down_ready, down_error,
    output busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_done, m0_rdata, m0_err,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_done, m1_rdata, m1_err,
    input  down_write, down_read, down_addr, down_wdata,
    output down_rdata, down_ready, down_error,
    input  busy
  );
endinterface

// File: rtl/spi_apb_arbiter.sv
// Two-master round-robin arbiter in front of an SPI bridge: in-window accesses
// go downstream with a BUSY timeout, everything else is answered locally with an error.
module spi_apb_arbiter #(
  parameter logic [31:0] SPI_BASE = 32'h1000_0000,
  parameter logic [31:0] SPI_END  = 32'h1000_0020,
  parameter int          TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  spi_apb_arbiter_if.slave  bus
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [31:0]   BAD_DATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOCAL    = 3'd1,
    ISSUE    = 3'd2,
    WAIT_ACK = 3'd3,
    BUSY     = 3'd4,
    RESP     = 3'd5,
    DRAIN    = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
  logic          down_write_q, down_write_d;
  logic          down_read_q, down_read_d;
  logic [31:0]   down_addr_q, down_addr_d;
  logic [31:0]   down_wdata_q, down_wdata_d;
  logic          m0_done_q, m0_done_d;
  logic [31:0]   m0_rdata_q, m0_rdata_d;
  logic          m0_err_q, m0_err_d;
  logic          m1_done_q, m1_done_d;
  logic [31:0]   m1_rdata_q, m1_rdata_d;
  logic          m1_err_q, m1_err_d;
  logic          busy_q, busy_d;

  logic          gnt_s;
  logic          sel_we_s;
  logic [31:0]   sel_addr_s;
  logic [31:0]   sel_wdata_s;
  logic          resp_valid_s;
  logic [31:0]   resp_rdata_s;
  logic          resp_err_s;

  function automatic logic in_window(input logic [31:0] a);
    return (a >= SPI_BASE) && (a < SPI_END);
  endfunction

  // Next-state, arbitration and response capture.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    down_write_d = 1'b0;
    down_read_d  = 1'b0;
    down_addr_d  = down_addr_q;
    down_wdata_d = down_wdata_q;
    m0_done_d    = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m0_err_d     = m0_err_q;
    m1_done_d    = 1'b0;
    m1_rdata_d   = m1_rdata_q;
    m1_err_d     = m1_err_q;
    resp_valid_s = 1'b0;
    resp_rdata_s = BAD_DATA;
    resp_err_s   = 1'b1;
    // Preferred master wins only when both request.
    gnt_s        = (bus.m0_req && bus.m1_req) ? ptr_q : bus.m1_req;
    sel_we_s     = gnt_s ? bus.m1_we    : bus.m0_we;
    sel_addr_s   = gnt_s ? bus.m1_addr  : bus.m0_addr;
    sel_wdata_s  = gnt_s ? bus.m1_wdata : bus.m0_wdata;

    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          owner_d = gnt_s;
          if (in_window(sel_addr_s)) begin
            state_d      = ISSUE;
            down_write_d = sel_we_s;
            down_read_d  = !sel_we_s;
            down_addr_d  = sel_addr_s;
            down_wdata_d = sel_wdata_s;
          end else begin
            state_d = LOCAL;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOCAL: begin
        resp_valid_s = 1'b1;
      end
      ISSUE: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        // A ready without a preceding BUSY phase is a protocol error.
        if (bus.down_error) begin
          resp_valid_s = 1'b1;
          resp_rdata_s = bus.down_rdata;
        end else if (!bus.down_ready) begin
          state_d = BUSY;
          cnt_d   = '0;
        end else begin
          resp_valid_s = 1'b1;
        end
      end
      BUSY: begin
        if (bus.down_ready) begin
          resp_valid_s = 1'b1;
          resp_rdata_s = bus.down_rdata;
          resp_err_s   = bus.down_error;
        end else if (cnt_q == CNT_LAST) begin
          resp_valid_s = 1'b1;
          tmo_d        = 1'b1;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      RESP: begin
        ptr_d   = ~owner_q;
        state_d = tmo_q ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (bus.down_ready) begin
          tmo_d   = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (resp_valid_s) begin
      state_d = RESP;
      if (owner_q) begin
        m1_done_d  = 1'b1;
        m1_rdata_d = resp_rdata_s;
        m1_err_d   = resp_err_s;
      end else begin
        m0_done_d  = 1'b1;
        m0_rdata_d = resp_rdata_s;
        m0_err_d   = resp_err_s;
      end
    end else begin
      m0_done_d = 1'b0;
      m1_done_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      tmo_q        <= 1'b0;
      down_write_q <= 1'b0;
      down_read_q  <= 1'b0;
      down_addr_q  <= 32'h0000_0000;
      down_wdata_q <= 32'h0000_0000;
      m0_done_q    <= 1'b0;
      m0_rdata_q   <= 32'h0000_0000;
      m0_err_q     <= 1'b0;
      m1_done_q    <= 1'b0;
      m1_rdata_q   <= 32'h0000_0000;
      m1_err_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      down_write_q <= down_write_d;
      down_read_q  <= down_read_d;
      down_addr_q  <= down_addr_d;
      down_wdata_q <= down_wdata_d;
      m0_done_q    <= m0_done_d;
      m0_rdata_q   <= m0_rdata_d;
      m0_err_q     <= m0_err_d;
      m1_done_q    <= m1_done_d;
      m1_rdata_q   <= m1_rdata_d;
      m1_err_q     <= m1_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.down_write = down_write_q;
  assign bus.down_read  = down_read_q;
  assign bus.down_addr  = down_addr_q;
  assign bus.down_wdata = down_wdata_q;
  assign bus.m0_done    = m0_done_q;
  assign bus.m0_rdata   = m0_rdata_q;
  assign bus.m0_err     = m0_err_q;
  assign bus.m1_done    = m1_done_q;
  assign bus.m1_rdata   = m1_rdata_q;
  assign bus.m1_err     = m1_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_spi_apb_arbiter.sv
// Bench for spi_apb_arbiter: table of single transactions plus hand sequences
// for arbitration order, bridge timeout/drain and reset in mid-transaction.
module tb_spi_apb_arbiter;

  logic clk;
  logic rst;

  spi_apb_arbiter_if bus ();

  spi_apb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        berr;
    logic [31:0] brdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_cyc;
    int          exp_down;   // 0 none, 1 write, 2 read
    logic        drop;
  } vec_t;

  typedef struct {
    logic        m;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t        tbl [8];
  exp_t        sbq [$];
  int          n_vec = 0;
  int          n_miss = 0;

  // bridge model state
  int          cfg_lat;
  logic        cfg_berr;
  logic [31:0] cfg_brdata;
  logic        pending;
  int          low_left;
  int          ready_pulses;

  // monitor state
  int          n_wr, n_rd;
  logic [31:0] cap_wdata;
  logic        done0, done1;
  logic [31:0] last_rdata [2];
  logic        last_err [2];
  logic [31:0] hold_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_m(input logic m, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (m) begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end else begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end
  endtask

  // One clock: bridge responder and scoreboard monitor, run at the falling edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    bus.down_ready = 1'b0;
    bus.down_error = 1'b0;
    if (!rst) begin
      pending = 1'b0;
    end else if (pending) begin
      if (low_left == 0) begin
        bus.down_ready = 1'b1;
        bus.down_error = cfg_berr;
        bus.down_rdata = cfg_brdata;
        pending        = 1'b0;
        ready_pulses++;
      end else begin
        low_left--;
      end
    end else if (bus.down_write || bus.down_read) begin
      pending  = 1'b1;
      low_left = cfg_lat;
    end
    if (bus.down_write) begin n_wr++; cap_wdata = bus.down_wdata; end
    if (bus.down_read) n_rd++;
    done0 = bus.m0_done;
    done1 = bus.m1_done;
    if (done0 || done1) begin
      chk("done_onehot", {31'd0, done0 & done1}, 32'd0);
      if (sbq.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL unexpected_done: got m0=%0b m1=%0b expected none", done0, done1);
      end else begin
        e = sbq.pop_front();
        chk("done_owner", {31'd0, done1}, {31'd0, e.m});
        chk("rdata", done1 ? bus.m1_rdata : bus.m0_rdata, e.rdata);
        chk("err", {31'd0, done1 ? bus.m1_err : bus.m0_err}, {31'd0, e.err});
        last_rdata[e.m] = e.rdata;
        last_err[e.m]   = e.err;
      end
    end
  endtask

  task automatic clear_model();
    last_rdata[0] = 32'd0; last_rdata[1] = 32'd0;
    last_err[0] = 1'b0; last_err[1] = 1'b0;
    hold_addr = 32'd0;
  endtask

  task automatic apply_reset();
    #2 rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    clear_model();
    tick();
  endtask

  task automatic run_txn(input vec_t v, input string name);
    int cyc;
    int wr0, rd0;
    logic got;
    wr0 = n_wr; rd0 = n_rd;
    cfg_lat = v.lat; cfg_berr = v.berr; cfg_brdata = v.brdata;
    sbq.push_back('{v.m, v.exp_rdata, v.exp_err});
    drive_m(v.m, 1'b1, v.we, v.addr, v.wdata);
    cyc = 0; got = 1'b0;
    while (!got && cyc < 100) begin
      tick();
      cyc++;
      if (cyc == 1 && v.drop) drive_m(v.m, 1'b0, v.we, v.addr, v.wdata);
      got = v.m ? done1 : done0;
    end
    drive_m(v.m, 1'b0, v.we, v.addr, v.wdata);
    if (!got) begin
      n_vec++; n_miss++; sbq.delete();
      $display("FAIL %s_timeout: got no done expected done in %0d cycles", name, v.exp_cyc);
    end else begin
      chk({name, "_latency"}, cyc, v.exp_cyc);
    end
    chk({name, "_n_write"}, n_wr - wr0, (v.exp_down == 1) ? 32'd1 : 32'd0);
    chk({name, "_n_read"}, n_rd - rd0, (v.exp_down == 2) ? 32'd1 : 32'd0);
    if (v.exp_down != 0) hold_addr = v.addr;
    chk({name, "_down_addr"}, bus.down_addr, hold_addr);
    if (v.exp_down == 1) chk({name, "_down_wdata"}, cap_wdata, v.wdata);
    chk({name, "_other_rdata"}, v.m ? bus.m0_rdata : bus.m1_rdata, last_rdata[!v.m]);
    tick();
    chk({name, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int   cyc;
    int   cnt0, cnt1;
    int   rp0;
    logic early;
    vec_t v;

    tbl[0] = '{1'b0, 1'b1, 32'h1000_0004, 32'h0000_00A5, 3, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 6, 1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 32'h2000_0000, 32'h0000_0000, 0, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 2, 0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 32'h1000_0002, 32'h0000_0000, 0, 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1, 3, 2, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 32'h1000_001C, 32'h0000_0000, 1, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 4, 2, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 32'h1000_0020, 32'h0000_0011, 0, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 2, 0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 32'h1000_0000, 32'h0000_0000, 0, 1'b0, 32'h5555_0000, 32'hDEAD_BEEF, 1'b1, 3, 2, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 32'h0FFF_FFFC, 32'h0000_0022, 2, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 2, 0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 32'h1000_0010, 32'h5A5A_0001, 2, 1'b1, 32'hBAD0_0001, 32'hBAD0_0001, 1'b1, 5, 1, 1'b1};

    rst = 1'b0;
    pending = 1'b0; low_left = 0; ready_pulses = 0;
    n_wr = 0; n_rd = 0; cap_wdata = 32'd0;
    cfg_lat = 0; cfg_berr = 1'b0; cfg_brdata = 32'd0;
    bus.down_ready = 1'b0; bus.down_error = 1'b0; bus.down_rdata = 32'd0;
    drive_m(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_m(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    clear_model();
    tick(); tick();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_m0_done", {31'd0, bus.m0_done}, 32'd0);
    chk("rst_m1_rdata", bus.m1_rdata, 32'd0);
    chk("rst_down_rw", {30'd0, bus.down_write, bus.down_read}, 32'd0);
    chk("rst_down_addr", bus.down_addr, 32'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i], $sformatf("vec%0d", i));
    end

    // Both masters request together after reset; m0 keeps its request past
    // its first done, so it competes again and must lose to m1.
    apply_reset();
    cfg_lat = 0; cfg_berr = 1'b0;
    sbq.push_back('{1'b0, 32'hDEAD_BEEF, 1'b1});
    sbq.push_back('{1'b1, 32'hDEAD_BEEF, 1'b1});
    sbq.push_back('{1'b0, 32'hDEAD_BEEF, 1'b1});
    drive_m(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'd0);
    drive_m(1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'd0);
    cnt0 = 0; cnt1 = 0; cyc = 0;
    while (!(cnt0 == 2 && cnt1 == 1) && cyc < 100) begin
      tick();
      cyc++;
      if (done0) begin cnt0++; if (cnt0 == 2) bus.m0_req = 1'b0; end
      if (done1) begin cnt1++; bus.m1_req = 1'b0; end
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    chk("arb_m0_count", cnt0, 32'd2);
    chk("arb_m1_count", cnt1, 32'd1);
    chk("arb_sb_empty", sbq.size(), 32'd0);
    sbq.delete();
    tick();

    // Bridge stuck low: timeout, then DRAIN blocks m1 until the bridge recovers.
    v = '{1'b0, 1'b0, 32'h1000_0008, 32'h0000_0000, 40, 1'b0, 32'h0000_0099, 32'hDEAD_BEEF, 1'b1, 19, 2, 1'b0};
    cfg_lat = v.lat; cfg_berr = v.berr; cfg_brdata = v.brdata;
    sbq.push_back('{1'b0, 32'hDEAD_BEEF, 1'b1});
    drive_m(1'b0, 1'b1, v.we, v.addr, v.wdata);
    cyc = 0;
    done0 = 1'b0;
    while (!done0 && cyc < 100) begin
      tick();
      cyc++;
    end
    bus.m0_req = 1'b0;
    chk("tmo_latency", cyc, 32'd19);
    rp0 = ready_pulses;
    sbq.push_back('{1'b1, 32'hDEAD_BEEF, 1'b1});
    drive_m(1'b1, 1'b1, 1'b0, 32'h3000_0000, 32'd0);
    tick();
    chk("tmo_drain_busy", {31'd0, bus.busy}, 32'd1);
    early = 1'b0;
    cyc = 0;
    done1 = 1'b0;
    while (!done1 && cyc < 100) begin
      tick();
      cyc++;
      if (done1 && ready_pulses == rp0) early = 1'b1;
    end
    bus.m1_req = 1'b0;
    chk("tmo_m1_done", {31'd0, done1}, 32'd1);
    chk("tmo_drain_hold", {31'd0, early}, 32'd0);
    chk("tmo_bridge_ready", ready_pulses - rp0, 32'd1);
    tick();

    // Reset lands while the bridge is still busy.
    cfg_lat = 10; cfg_berr = 1'b0;
    drive_m(1'b0, 1'b1, 1'b1, 32'h1000_000C, 32'h0000_BEEF);
    tick(); tick(); tick(); tick();
    chk("mid_busy", {31'd0, bus.busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_m0_done", {31'd0, bus.m0_done}, 32'd0);
    chk("mid_rst_m0_rdata", bus.m0_rdata, 32'd0);
    chk("mid_rst_m1_rdata", bus.m1_rdata, 32'd0);
    chk("mid_rst_m1_err", {31'd0, bus.m1_err}, 32'd0);
    chk("mid_rst_down_rw", {30'd0, bus.down_write, bus.down_read}, 32'd0);
    chk("mid_rst_down_addr", bus.down_addr, 32'd0);
    chk("mid_rst_down_wdata", bus.down_wdata, 32'd0);
    bus.m0_req = 1'b0;
    clear_model();
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    v = '{1'b0, 1'b1, 32'h1000_0008, 32'h0000_1234, 1, 1'b0, 32'h0000_0077, 32'h0000_0077, 1'b0, 4, 1, 1'b0};
    run_txn(v, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
